control_sequencer: RTL

Microcoded control sequencer for the 8-bit CPU. It steps a T-state counter through the fetch and execute phases and decodes the 4-bit opcode from the instruction register into one-cycle load, output and increment enables. These enables drive the clock-enable inputs of the PC, MAR, IR, A, B, OUT and flags registers and the bus-drive selects. It owns all bus sequencing; no other block asserts register loads.

---
 rtl/control_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Purpose: microcoded T-state sequencer that decodes the IR opcode into one-cycle register/bus enables.
// Latency: enables are combinational within the current step; t_state/halted update on each rising edge.
// Backpressure: enable=0 freezes the step and zeroes enables; halted holds T0 until clear.
module control_sequencer (
    input  logic       clock,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic [2:0] t_state,
    output logic       halted,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstep_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    tstep_e step_q;
    logic   halted_q;
    logic   last_step;
    logic   run;

    assign t_state = step_q;
    assign halted  = halted_q;
    assign run     = !clear && enable && !halted_q;

    // Decide whether the current step ends the instruction. NOP's early end at T1
    // is the one place the opcode is consulted before the IR load lands.
    always_comb begin
        last_step = 1'b1;
        case (step_q)
            T0:      last_step = 1'b0;
            T1:      last_step = (opcode == OP_NOP);
            T2:      last_step = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA});
            T3:      last_step = !(opcode inside {OP_ADD, OP_SUB});
            default: last_step = 1'b1;
        endcase
    end

    // Step counter and halt latch; clear wins over everything, a frozen or halted
    // sequencer holds its state.
    always_ff @(posedge clock) begin
        if (clear) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (enable && !halted_q) begin
            if (last_step || step_q == T5) begin
                step_q <= T0;
            end else begin
                step_q <= tstep_e'(step_q + 3'd1);
            end
            if (step_q == T2 && opcode == OP_HLT) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Microcode decode: one set of enables per (step, opcode); all zero when not running.
    always_comb begin
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_load   = 1'b0;
        ram_out    = 1'b0;
        ram_in     = 1'b0;
        ir_load    = 1'b0;
        ir_out     = 1'b0;
        a_load     = 1'b0;
        a_out      = 1'b0;
        b_load     = 1'b0;
        alu_out    = 1'b0;
        alu_sub    = 1'b0;
        flags_load = 1'b0;
        out_load   = 1'b0;
        if (run) begin
            case (step_q)
                T0: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                T1: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out   = 1'b1;
                            mar_load = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_load = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_JC: begin
                            ir_out  = 1'b1;
                            pc_load = carry_flag;
                        end
                        OP_JZ: begin
                            ir_out  = 1'b1;
                            pc_load = zero_flag;
                        end
                        OP_OUT: begin
                            a_out    = 1'b1;
                            out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_load  = 1'b1;
                            alu_sub = (opcode == OP_SUB);
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out    = 1'b1;
                        a_load     = 1'b1;
                        flags_load = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
